// File: rtl/jt49_bus_arb_pkg.sv
// Shared definitions for the jt49 bus arbiter: FSM states, strobe counter
// width, shadow register reset values and the per-register read mask.
package jt49_bus_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_WAIT    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   // Width of the write-strobe down-counter (STROBE_LEN up to 15)
   localparam int CNT_W = 4;

   // Shadow covers R0..R13; R14/R15 are I/O ports and always go to the bus
   localparam int         SHADOW_REGS      = 14;
   localparam logic [3:0] LAST_SHADOW_ADDR = 4'd13;
   localparam logic [7:0] SHADOW_RST       = 8'h00;
   localparam logic [7:0] SHADOW_R7_RST    = 8'hFF;

   // Bits actually implemented in each PSG register as seen on a read
   function automatic logic [7:0] read_mask(input logic [3:0] addr);
      case (addr)
         4'd1, 4'd3, 4'd5, 4'd13: read_mask = 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: read_mask = 8'h1F;
         default:                 read_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/jt49_arb_rr.sv
// Two-way request picker: round-robin or fixed priority (A wins).
// last_b remembers which port was granted most recently.
module jt49_arb_rr (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,       // {B, A}
   input  logic       rr_mode,
   input  logic       grant_en,
   output logic [1:0] grant,     // one-hot {B, A}
   output logic       last_b
);

   // Pick one requester; on a tie the pointer decides in round-robin mode
   always_comb begin
      grant = 2'b00;
      if (grant_en) begin
         if (req == 2'b11)
            grant = (rr_mode && !last_b) ? 2'b10 : 2'b01;
         else
            grant = req;
      end
   end

   // Pointer starts as "B last" so the first contested grant goes to A
   always_ff @(posedge clk) begin
      if (rst)
         last_b <= 1'b1;
      else if (|grant)
         last_b <= grant[1];
   end

endmodule

// File: rtl/jt49_bus_arb.sv
// Arbiter and bus sequencer sharing the jt49 PSG register port between
// requesters A and B. Every access is framed by cs_n, and cs_n returns high
// for at least one cycle between accesses so each R13 write retriggers the
// envelope. Optional register shadow for fast reads: JT49_BUS_ARB_SHADOW_EN.
module jt49_bus_arb
   import jt49_bus_arb_pkg::*;
#(
   parameter int STROBE_LEN = 2,
   parameter bit RR         = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_req,
   input  logic       a_we,
   input  logic [3:0] a_addr,
   input  logic [7:0] a_din,
   output logic       a_ack,
   output logic [7:0] a_dout,
   input  logic       b_req,
   input  logic       b_we,
   input  logic [3:0] b_addr,
   input  logic [7:0] b_din,
   output logic       b_ack,
   output logic [7:0] b_dout,
   output logic [3:0] psg_addr,
   output logic       psg_cs_n,
   output logic       psg_wr_n,
   output logic [7:0] psg_din,
   input  logic [7:0] psg_dout,
   output logic       busy
);

   state_t           state;
   logic [CNT_W-1:0] strobe_cnt;
   logic             lat_we;
   logic [1:0]       grant;
   logic             cur_b;
   logic             grant_en;
   logic             req_we;
   logic [3:0]       req_addr;
   logic [7:0]       req_din;
   logic             shadow_hit;
   logic [7:0]       shadow_rd;

   // No new grant while an ack is on the wire, so a requester still holding
   // req during its own ack cycle is not served twice.
   assign grant_en = (state == ST_IDLE) && !a_ack && !b_ack;
   assign busy     = (state != ST_IDLE);

   // The pointer is updated at every grant, so after the grant edge it also
   // identifies the port that owns the transaction in flight.
   jt49_arb_rr u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      ({b_req, a_req}),
      .rr_mode  (RR),
      .grant_en (grant_en),
      .grant    (grant),
      .last_b   (cur_b)
   );

   assign req_we   = grant[1] ? b_we   : a_we;
   assign req_addr = grant[1] ? b_addr : a_addr;
   assign req_din  = grant[1] ? b_din  : a_din;

`ifdef JT49_BUS_ARB_SHADOW_EN
   logic [7:0] shadow [SHADOW_REGS];

   // Mirror every completed write to R0..R13; psg_addr/psg_din still hold
   // the transaction's address and data during RECOVER.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SHADOW_REGS; i++)
            shadow[i] <= (i == 7) ? SHADOW_R7_RST : SHADOW_RST;
      end else if (state == ST_RECOVER && lat_we) begin
         for (int i = 0; i < SHADOW_REGS; i++)
            if (psg_addr == 4'(i))
               shadow[i] <= psg_din;
      end
   end

   // Read port of the shadow, addressed by the requester being granted
   always_comb begin
      shadow_rd = 8'h00;
      for (int i = 0; i < SHADOW_REGS; i++)
         if (req_addr == 4'(i))
            shadow_rd = shadow[i];
   end

   assign shadow_hit = !req_we && (req_addr <= LAST_SHADOW_ADDR);
`else
   assign shadow_hit = 1'b0;
   assign shadow_rd  = 8'h00;
`endif

   // Bus sequencer; psg_addr/psg_din double as the latched address and data
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         strobe_cnt <= '0;
         lat_we     <= 1'b0;
         psg_addr   <= 4'h0;
         psg_din    <= 8'h00;
         psg_cs_n   <= 1'b1;
         psg_wr_n   <= 1'b1;
         a_ack      <= 1'b0;
         b_ack      <= 1'b0;
         a_dout     <= 8'h00;
         b_dout     <= 8'h00;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  if (shadow_hit) begin
                     // Answered from the shadow; the PSG bus stays untouched
                     if (grant[1]) begin
                        b_ack  <= 1'b1;
                        b_dout <= shadow_rd & read_mask(req_addr);
                     end else begin
                        a_ack  <= 1'b1;
                        a_dout <= shadow_rd & read_mask(req_addr);
                     end
                  end else begin
                     lat_we   <= req_we;
                     psg_addr <= req_addr;
                     psg_din  <= req_din;
                     psg_cs_n <= 1'b0;
                     psg_wr_n <= 1'b1;
                     state    <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               strobe_cnt <= CNT_W'(STROBE_LEN - 1);
               if (lat_we) begin
                  psg_wr_n <= 1'b0;
                  state    <= ST_STROBE;
               end else begin
                  state    <= ST_WAIT;
               end
            end
            ST_STROBE: begin
               if (strobe_cnt == '0) begin
                  psg_cs_n <= 1'b1;
                  psg_wr_n <= 1'b1;
                  a_ack    <= !cur_b;
                  b_ack    <= cur_b;
                  state    <= ST_RECOVER;
               end else begin
                  strobe_cnt <= strobe_cnt - 1'b1;
               end
            end
            ST_WAIT: begin
               if (cur_b)
                  b_dout <= psg_dout;
               else
                  a_dout <= psg_dout;
               psg_cs_n <= 1'b1;
               a_ack    <= !cur_b;
               b_ack    <= cur_b;
               state    <= ST_RECOVER;
            end
            ST_RECOVER: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/jt49_bus_arb.md
Name: jt49_bus_arb

Overview:
- Two-requester arbiter and bus sequencer in front of the jt49 PSG register interface (addr/cs_n/wr_n/din/dout).
- Shares the PSG between the CPU-side port A and a secondary requester on port B (replay engine / save-state restore).
- Generates correctly timed write strobes, with cs_n/wr_n deasserted between every access. The PSG's envelope restart on R13 is edge-triggered, so back-to-back R13 writes must each restart the envelope.
- Returns read data with a single-cycle ack.

Parameters:
- STROBE_LEN, 2: clk cycles wr_n is held low per write (legal 1..15).
- RR, 1: 1 = round-robin between A and B; 0 = fixed priority, A always wins.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  port A 1 = write, 0 = read
- a_addr  in  4  port A PSG register address
- a_din  in  8  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_dout  out  8  port A read data, valid while a_ack is high
- b_req, b_we, b_addr, b_din, b_ack, b_dout: same as port A, for port B
- psg_addr  out  4  to jt49 addr
- psg_cs_n  out  1  to jt49 cs_n
- psg_wr_n  out  1  to jt49 wr_n
- psg_din  out  8  to jt49 din
- psg_dout  in  8  from jt49 dout (registered there; tracks addr one clk later)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State IDLE; psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0.
  - a_ack=b_ack=0, a_dout=b_dout=0, busy=0; RR pointer favours A.
  - A reset mid-transaction aborts it: no ack is issued, and the bus is released the cycle after reset.
- States: IDLE, SETUP, STROBE, WAIT, RECOVER. Acks are only ever asserted in RECOVER, or in IDLE for shadow hits when the optional feature is enabled.
- IDLE:
  - If any req is high, grant one requester and latch its we/addr/din into internal registers. Later changes on the request inputs have no effect on the transaction in flight.
  - Then go to SETUP.
- Arbitration:
  - RR=1: if both request, grant the port not granted last; the pointer updates on every grant.
  - RR=0: A wins.
- SETUP (1 cycle): psg_addr=latched addr, psg_cs_n=0, psg_wr_n=1, psg_din=latched data. Next state is STROBE for a write, WAIT for a read.
- STROBE (STROBE_LEN cycles):
  - psg_cs_n=0, psg_wr_n=0, with addr/din held.
  - A 4-bit down-counter loaded in SETUP controls the exit to RECOVER.
- WAIT (1 cycle): cs_n=0, wr_n=1; psg_dout is valid at the end of this cycle and is captured into the granted port's dout register.
- RECOVER (1 cycle):
  - psg_cs_n=1, psg_wr_n=1.
  - Pulse the granted port's ack; for reads its dout holds the captured value.
  - Next state IDLE, so there is always at least one cycle with cs_n=1 between accesses.
- Latency (grant cycle = 0):
  - Write ack at cycle 2+STROBE_LEN.
  - Read ack at cycle 3.
- The non-granted port's ack stays 0, and its dout holds its previous value.
- If a requester drops req before its ack, the transaction still completes and the ack is still pulsed.
- Request hold rules:
  - A port whose req stays high after its ack is treated as a new request at the next IDLE.
  - Under RR=1, A and B alternate when both are continuously requesting.

Optional Feature:
- Macro: JT49_BUS_ARB_SHADOW_EN.
- When defined:
  - A 14x8 shadow of R0..R13 is updated with the latched data whenever a write to addr<=13 completes (in RECOVER).
  - Shadow reset value: all 0x00 except R7=0xFF.
  - A granted read with addr<=13 is answered in the grant cycle. Ack is pulsed in IDLE the cycle after grant, with dout = shadow & mask; the state stays IDLE and the PSG bus is untouched.
  - Masks: 0x0F for R1, R3, R5, R13; 0x1F for R6, R8, R9, R10; 0xFF otherwise.
  - Reads of R14/R15 always go to the bus.
- When undefined: every read uses the bus sequence above, and no shadow storage exists.

Decomposition:
- Package jt49_bus_arb_pkg:
  - state encoding constants;
  - read-mask function (addr to mask);
  - shadow reset constants (R7 = 0xFF);
  - STROBE counter width.
- Sub-module jt49_arb_rr: 2-way round-robin/fixed-priority picker. Inputs are req pair, RR mode and grant-enable; outputs are a one-hot grant and the registered last-grant pointer.

Test Plan:
- Single A write, addr=0xD, din=0x0E, STROBE_LEN=2 -> cs_n low cycles 1–3, wr_n low cycles 2–3, a_ack at cycle 4, b_ack stays 0.
- Two back-to-back A writes to R13 -> psg_cs_n=1 for at least 1 cycle between them; PSG eg_restart pulses twice.
- Read of R7 after reset, shadow off -> a_ack at cycle 3 with a_dout=0xFF; with JT49_BUS_ARB_SHADOW_EN -> ack at cycle 1, no cs_n activity.
- A and B both requesting continuously, RR=1 -> grants A,B,A,B; with RR=0 -> A only while a_req is held.
- B write to R8 value 0xFF then shadow read of R8 -> b_dout=0x1F.
- rst asserted during STROBE -> next cycle cs_n=1, wr_n=1, no ack; first post-reset grant goes to A.
